// File: rtl/button_debouncer.sv
// Debounced push-button front end: two-flop synchronizer, debounce FSM,
// registered level plus press/release/long-press pulses and a press counter.
module button_debouncer #(
    parameter logic [31:0] STABLE_CYCLES     = 32'd1_000_000,
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd100_000_000,
    parameter logic        ACTIVE_HIGH       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_in,
    output logic        btn_level,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        long_press_pulse,
    output logic [15:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED         = 2'b00,
        DEBOUNCE_PRESS   = 2'b01,
        PRESSED          = 2'b10,
        DEBOUNCE_RELEASE = 2'b11
    } state_t;

    localparam logic        PIN_IDLE    = ~ACTIVE_HIGH;
    localparam logic [31:0] STABLE_LAST = STABLE_CYCLES - 32'd1;
    localparam logic [31:0] LONG_LAST   = LONG_PRESS_CYCLES - 32'd1;

    logic        r_s1;
    logic        r_s2;
    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_deb_cnt;
    logic [31:0] r_hold_cnt;
    logic        r_fired;
    logic        r_level;
    logic        r_press_pulse;
    logic        r_release_pulse;
    logic        r_long_pulse;
    logic [15:0] r_press_count;

    logic        w_deb_clr;
    logic        w_deb_inc;
    logic        w_accept_press;
    logic        w_accept_release;
    logic        w_level_next;
    logic        w_holding;
    logic        w_long_fire;

    // s1 holds the raw pin; polarity is normalized on the way into s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= PIN_IDLE;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= (r_s1 == ACTIVE_HIGH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RELEASED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_deb_clr        = 1'b0;
        w_deb_inc        = 1'b0;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            RELEASED: begin
                if (r_s2) begin
                    w_state_next = DEBOUNCE_PRESS;
                    w_deb_clr    = 1'b1;
                end
            end
            DEBOUNCE_PRESS: begin
                if (!r_s2) begin
                    w_state_next = RELEASED;
                    w_deb_clr    = 1'b1;
                end else if (r_deb_cnt == STABLE_LAST) begin
                    w_state_next   = PRESSED;
                    w_deb_clr      = 1'b1;
                    w_accept_press = 1'b1;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            PRESSED: begin
                if (!r_s2) begin
                    w_state_next = DEBOUNCE_RELEASE;
                    w_deb_clr    = 1'b1;
                end
            end
            DEBOUNCE_RELEASE: begin
                if (r_s2) begin
                    w_state_next = PRESSED;
                    w_deb_clr    = 1'b1;
                end else if (r_deb_cnt == STABLE_LAST) begin
                    w_state_next     = RELEASED;
                    w_deb_clr        = 1'b1;
                    w_accept_release = 1'b1;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = RELEASED;
                w_deb_clr    = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_level_next = (w_state_next == PRESSED) || (w_state_next == DEBOUNCE_RELEASE);
        w_holding    = (r_state == PRESSED) || (r_state == DEBOUNCE_RELEASE);
        w_long_fire  = w_holding && !r_fired && (r_hold_cnt == LONG_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst || w_deb_clr) begin
            r_deb_cnt <= '0;
        end else if (w_deb_inc) begin
            r_deb_cnt <= r_deb_cnt + 32'd1;
        end
    end

    // Hold counter stops once the long press fires, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_fired    <= 1'b0;
        end else if (w_accept_press) begin
            r_hold_cnt <= '0;
            r_fired    <= 1'b0;
        end else begin
            if (w_holding && !r_fired && !w_long_fire) begin
                r_hold_cnt <= r_hold_cnt + 32'd1;
            end
            if (w_accept_release) begin
                r_fired <= 1'b0;
            end else if (w_long_fire) begin
                r_fired <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level         <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_level         <= w_level_next;
            r_press_pulse   <= w_accept_press;
            r_release_pulse <= w_accept_release;
            r_long_pulse    <= w_long_fire;
            if (w_accept_press) begin
                r_press_count <= r_press_count + 16'd1;
            end
        end
    end

    assign btn_level        = r_level;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;
    assign press_count      = r_press_count;

endmodule
